// File: rtl/inst_rom.sv
// inst_rom: instruction memory with zero-latency fetch port and a byte-stream
// loader that fills the memory with big-endian words before the core runs.
// Optional build macro: INST_ROM_CKSUM_EN enables the running word checksum
// on o_cksum; without it o_cksum is tied to zero.
module inst_rom #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic [31:0]       i_addr,
    output logic [31:0]       o_inst,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_ld_done,
    output logic [ADDR_W:0]   o_ld_words,
    output logic [31:0]       o_cksum
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_buf;
    logic [ADDR_W:0]   r_words;
    logic [31:0]       r_mem [DEPTH];

    logic              w_hs;
    logic              w_wr;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_fidx;
    logic              w_frange;

    // A byte handshaked on the same edge as a restart is dropped.
    assign w_hs = (r_state == LOAD) && i_ld_valid && !i_ld_start;
    assign w_wr = w_hs && ((r_bcnt == 2'd3) || i_ld_last);

    // Merge buffered high bytes with the incoming byte; unfilled low bytes stay zero.
    always_comb begin
        w_word = 32'h0;
        case (r_bcnt)
            2'd0:    w_word = {i_ld_data, 24'h0};
            2'd1:    w_word = {r_buf[23:16], i_ld_data, 16'h0};
            2'd2:    w_word = {r_buf[23:8], i_ld_data, 8'h0};
            default: w_word = {r_buf[23:0], i_ld_data};
        endcase
    end

    // Loader state machine, byte buffer and word counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_bcnt  <= 2'd0;
            r_buf   <= 24'h0;
            r_words <= '0;
        end else if (i_ld_start) begin
            r_state <= LOAD;
            r_bcnt  <= 2'd0;
            r_buf   <= 24'h0;
            r_words <= '0;
        end else if (w_hs) begin
            if (w_wr) begin
                r_bcnt  <= 2'd0;
                r_buf   <= 24'h0;
                r_words <= r_words + 1'b1;
                if (i_ld_last || (r_words == LAST_IDX))
                    r_state <= DONE;
            end else begin
                r_bcnt <= r_bcnt + 2'd1;
                case (r_bcnt)
                    2'd0:    r_buf[23:16] <= i_ld_data;
                    2'd1:    r_buf[15:8]  <= i_ld_data;
                    default: r_buf[7:0]   <= i_ld_data;
                endcase
            end
        end
    end

    // Memory write port; the array is not reset so images survive a core reset.
    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_words[ADDR_W-1:0]] <= w_word;
    end

`ifdef INST_ROM_CKSUM_EN
    logic [31:0] r_cksum;

    // Running modulo-2^32 sum of every word written in the current load.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_cksum <= 32'h0;
        else if (i_ld_start)
            r_cksum <= 32'h0;
        else if (w_wr)
            r_cksum <= r_cksum + w_word;
    end

    assign o_cksum = r_cksum;
`else
    assign o_cksum = 32'h0;
`endif

    // Fetch: combinational read, NOP when disabled, loading, or out of range.
    assign w_fidx   = i_addr[ADDR_W+1:2];
    assign w_frange = (i_addr[31:ADDR_W+2] == '0);

    always_comb begin
        o_inst = 32'h0;
        if (i_ce && (r_state != LOAD) && w_frange)
            o_inst = r_mem[w_fidx];
    end

    assign o_ld_ready = (r_state == LOAD);
    assign o_ld_done  = (r_state == DONE);
    assign o_ld_words = r_words;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a default-depth instance and a 4-word instance.
module tb_inst_rom;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        ld_start, ld_valid, ld_last, ld_ready, ld_done;
    logic [7:0]  ld_data;
    logic [10:0] ld_words;
    logic [31:0] cksum;

    logic        s_ce;
    logic [31:0] s_addr;
    logic [31:0] s_inst;
    logic        s_start, s_valid, s_last, s_ready, s_done;
    logic [7:0]  s_data;
    logic [2:0]  s_words;
    logic [31:0] s_cksum;

    int checks = 0;
    int errors = 0;

    inst_rom #(.ADDR_W(10)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr), .o_inst(inst),
        .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_data(ld_data),
        .i_ld_last(ld_last), .o_ld_ready(ld_ready), .o_ld_done(ld_done),
        .o_ld_words(ld_words), .o_cksum(cksum)
    );

    inst_rom #(.ADDR_W(2)) u_small (
        .i_clk(clk), .i_rst(rst), .i_ce(s_ce), .i_addr(s_addr), .o_inst(s_inst),
        .i_ld_start(s_start), .i_ld_valid(s_valid), .i_ld_data(s_data),
        .i_ld_last(s_last), .o_ld_ready(s_ready), .o_ld_done(s_done),
        .o_ld_words(s_words), .o_cksum(s_cksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ck(input logic [31:0] v);
`ifdef INST_ROM_CKSUM_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1; addr = 32'h0;
        #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want %h", inst, 32'h0); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ld_ready); end
        checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ld_done); end
        checks++; if (ld_words !== 11'd0) begin errors++; $display("FAIL reset_words got %0d want 0", ld_words); end
        checks++; if (cksum !== 32'h0) begin errors++; $display("FAIL reset_cksum got %h want 0", cksum); end
    endtask

    task automatic test_load();
        logic [7:0] img [8];
        img = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        start();
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", ld_ready); end
        ce = 1'b1; addr = 32'h0;
        for (int i = 0; i < 8; i++) send(img[i], i == 7);
        checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL load_done got %b want 1", ld_done); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_ready_off got %b want 0", ld_ready); end
        checks++; if (ld_words !== 11'd2) begin errors++; $display("FAIL load_words got %0d want 2", ld_words); end
        checks++; if (inst !== 32'h34020001) begin errors++; $display("FAIL load_a0 got %h want 34020001", inst); end
        addr = 32'h4; #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL load_a4 got %h want 0", inst); end
        addr = 32'h6; #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL load_a6 got %h want 0", inst); end
        addr = 32'h2; #1;
        checks++; if (inst !== 32'h34020001) begin errors++; $display("FAIL load_a2 got %h want 34020001", inst); end
        ce = 1'b0; addr = 32'h0; #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL load_ce0 got %h want 0", inst); end
        checks++; if (cksum !== ck(32'h34020001)) begin errors++; $display("FAIL load_cksum got %h want %h", cksum, ck(32'h34020001)); end
        ce = 1'b1;
    endtask

    task automatic test_short_last();
        start();
        addr = 32'h0; #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL short_nop_in_load got %h want 0", inst); end
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b1);
        checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL short_done got %b want 1", ld_done); end
        checks++; if (ld_words !== 11'd1) begin errors++; $display("FAIL short_words got %0d want 1", ld_words); end
        checks++; if (inst !== 32'hABCD0000) begin errors++; $display("FAIL short_a0 got %h want abcd0000", inst); end
        checks++; if (cksum !== ck(32'hABCD0000)) begin errors++; $display("FAIL short_cksum got %h want %h", cksum, ck(32'hABCD0000)); end
    endtask

    task automatic test_full_depth();
        s_start = 1'b1; tick(); s_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = 8'(i + 1); s_last = 1'b0;
            tick();
        end
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", s_done); end
        checks++; if (s_words !== 3'd4) begin errors++; $display("FAIL full_words got %0d want 4", s_words); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", s_ready); end
        s_data = 8'hEE; tick(); s_valid = 1'b0;
        checks++; if (s_words !== 3'd4 || s_done !== 1'b1) begin errors++; $display("FAIL full_extra got words %0d done %b want 4 1", s_words, s_done); end
        s_ce = 1'b1; s_addr = 32'h10; #1;
        checks++; if (s_inst !== 32'h0) begin errors++; $display("FAIL full_oor got %h want 0", s_inst); end
        s_addr = 32'h0; #1;
        checks++; if (s_inst !== 32'h01020304) begin errors++; $display("FAIL full_a0 got %h want 01020304", s_inst); end
        s_addr = 32'hC; #1;
        checks++; if (s_inst !== 32'h0D0E0F10) begin errors++; $display("FAIL full_ac got %h want 0d0e0f10", s_inst); end
        checks++; if (s_cksum !== ck(32'h1C202428)) begin errors++; $display("FAIL full_cksum got %h want %h", s_cksum, ck(32'h1C202428)); end
    endtask

    task automatic test_restart();
        start();
        for (int i = 0; i < 6; i++) send(8'(8'h11 + i), 1'b0);
        checks++; if (ld_words !== 11'd1) begin errors++; $display("FAIL rs_pre_words got %0d want 1", ld_words); end
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h77;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        checks++; if (ld_words !== 11'd0) begin errors++; $display("FAIL rs_words got %0d want 0", ld_words); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got %b want 1", ld_ready); end
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b1);
        addr = 32'h0; #1;
        checks++; if (inst !== 32'hA1A2A3A4) begin errors++; $display("FAIL rs_a0 got %h want a1a2a3a4", inst); end
        checks++; if (ld_words !== 11'd1) begin errors++; $display("FAIL rs_post_words got %0d want 1", ld_words); end
        checks++; if (cksum !== ck(32'hA1A2A3A4)) begin errors++; $display("FAIL rs_cksum got %h want %h", cksum, ck(32'hA1A2A3A4)); end
    endtask

    task automatic test_rst_midload();
        start();
        send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        send(8'hC5, 1'b0);
        rst = 1'b0; #1;
        checks++; if (ld_ready !== 1'b0 || ld_done !== 1'b0) begin errors++; $display("FAIL rst_flags got ready %b done %b want 0 0", ld_ready, ld_done); end
        checks++; if (ld_words !== 11'd0) begin errors++; $display("FAIL rst_words got %0d want 0", ld_words); end
        checks++; if (cksum !== 32'h0) begin errors++; $display("FAIL rst_cksum got %h want 0", cksum); end
        tick();
        rst = 1'b1;
        tick();
        ce = 1'b1; addr = 32'h0; #1;
        checks++; if (inst !== 32'hC1C2C3C4) begin errors++; $display("FAIL rst_a0 got %h want c1c2c3c4", inst); end
        addr = 32'h4; #1;
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_a4 got %h want 0", inst); end
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; addr = 32'h0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h0; ld_last = 1'b0;
        s_ce = 1'b0; s_addr = 32'h0;
        s_start = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_load();
        test_short_last();
        test_full_depth();
        test_restart();
        test_rst_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction memory answering the core's fetch port (chip enable, 32-bit byte address, 32-bit instruction data), plus a byte-stream loader that fills the memory before the core is released from reset. Fetch reads are zero-latency combinational so the fetch/decode pipeline register captures the PC and the instruction on the same edge. The loader is a small state machine that assembles big-endian words from a valid/ready byte stream, counts them, and signals completion.

## Interface
- ADDR_W, 10, word-address width; memory depth DEPTH = 2**ADDR_W 32-bit words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ce  in  1  fetch enable from core
- addr  in  32  fetch byte address from core
- inst  out  32  instruction to core
- ld_start  in  1  pulse: begin/restart a load at word 0
- ld_valid  in  1  byte available on ld_data
- ld_data  in  8  load byte
- ld_last  in  1  qualifies final byte of image, valid with ld_valid
- ld_ready  out  1  loader accepts a byte this cycle
- ld_done  out  1  load finished, held until next ld_start
- ld_words  out  ADDR_W+1  number of words written in current/last load
- cksum  out  32  running 32-bit sum of written words (see Configuration)

## Operation
- Fetch: word index = addr[ADDR_W+1:2]; addr[1:0] ignored. inst = mem[index] when ce=1, state != LOAD, and addr[31:ADDR_W+2] == 0; otherwise inst = 0 (NOP).
- Memory array has no reset; contents survive rst.
- States: IDLE (after reset), LOAD, DONE.
  - IDLE/DONE --ld_start--> LOAD; counters, byte buffer, ld_words, cksum cleared; ld_done cleared.
  - LOAD: byte accepted on edge where ld_valid && ld_ready. Bytes fill word big-endian (first byte -> bits 31:24). Byte counter 0..3.
  - On acceptance of 4th byte, or of any byte with ld_last=1: word written to mem[ld_words], unfilled low bytes zero, ld_words += 1, cksum += word (mod 2**32), byte counter -> 0.
  - ld_last accepted -> DONE. Word written that makes ld_words == DEPTH -> DONE even without ld_last.
  - ld_start while in LOAD: restart (same clearing), stay LOAD; a byte handshaked on that same edge is discarded.
- ld_ready = 1 only in LOAD; ld_done = 1 only in DONE.
- ld_valid while not in LOAD: ignored, no effect.

## Timing
- Reset values: state IDLE, ld_ready 0, ld_done 0, ld_words 0, cksum 0, byte counter 0; inst follows combinational rule (0 unless ce and not LOAD).
- ld_start at edge N -> ld_ready=1 from cycle N+1; first byte can be accepted at edge N+1.
- Full-rate: one byte per cycle, one word per 4 cycles; word visible on fetch port from the cycle after its 4th byte edge (once state has left LOAD).
- Final word write and transition to DONE occur on the same edge; ld_done=1, ld_ready=0 the following cycle.
- rst asserted mid-load: immediate return to IDLE, partial byte buffer lost, already-written words remain in memory.
- Fetch latency: 0 cycles (combinational addr/ce -> inst).

## Configuration
- INST_ROM_CKSUM_EN defined: cksum accumulator implemented as above.
- Not defined: accumulator omitted, cksum tied to 32'h0.

## Test plan
- Reset then ce=1, addr=0 -> inst=0, ld_ready=0, ld_done=0, ld_words=0.
- ld_start; stream 8'h34,8'h02,8'h00,8'h01 then 8'h00,8'h00,8'h00,8'h00 with ld_last on 8th byte -> ld_done=1, ld_words=2; fetch addr 0 -> 32'h34020001, addr 4 -> 0, addr 6 -> 0; cksum=32'h34020001 with macro, 0 without.
- ld_last on 2nd byte (8'hAB,8'hCD) -> mem[0]=32'hABCD0000, ld_words=1, DONE.
- ADDR_W=2, stream 16 bytes with no ld_last -> DONE after 16th byte, ld_words=4, 17th ld_valid ignored (ld_ready=0); fetch addr 32'h10 -> 0 (out of range).
- Mid-load: 6 bytes accepted, then ld_start coincident with a 7th handshake -> ld_words=0, byte dropped; next 4 bytes land in mem[0].
- Mid-load rst low for one cycle after word 1 written -> IDLE, ld_words=0, mem[0] retains data, readable with ce=1.
